// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared register-file widths and the x0 index
// Purpose: widths used by the register file, ALU and decoder, plus the x0 index.
// Ports: none (package).
package reg_file_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int WR_CNT_W  = 16;

  // Index of the hard-wired zero register.
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  // True when an index names a real (writable) register rather than x0.
  function automatic logic is_real_reg(input logic [RF_ADDR_W-1:0] idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - one combinational read port with x0 masking and write bypass
// Purpose: selects the value seen by one ALU operand.
// Ports:
//   addr     in  read index
//   we       in  write enable of the writeback port
//   rd_addr  in  writeback index
//   rd_data  in  writeback value
//   stored   in  value currently held in regs[addr]
//   data     out operand value
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = stored;
    if (addr == '0) begin
      // x0 wins over the bypass, so a dropped write to x0 is never forwarded.
      data = '0;
    end else if (BYPASS && we && (rd_addr == addr)) begin
      // Write-first: the writeback in flight this cycle reaches the ALU without a stall.
      data = rd_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 integer register file, two bypassed read ports, one write port
// Purpose: operand source for the ALU; x0 reads as zero; same-cycle writeback forwarding.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rs1_addr / rs1_data  read port 1 (ALU operand a)
//   rs2_addr / rs2_data  read port 2 (ALU operand b)
//   we, rd_addr, rd_data writeback port
//   dbg_addr / dbg_data  debug read of stored value (never bypassed)
//   wr_count             committed writes excluding x0, wraps at 2**16
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ADDR_W-1:0]   rs1_addr,
  output logic [DATA_W-1:0]   rs1_data,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rs2_data,
  input  logic                we,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data,
  output logic [WR_CNT_W-1:0] wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_commit;

  // A write to x0 is dropped entirely: no storage update, no count.
  assign wr_commit = we && (rd_addr != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr_commit) begin
      regs[rd_addr] <= rd_data;
      wr_count      <= wr_count + 1'b1;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rs1 (
    .addr    (rs1_addr),
    .we      (we),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .stored  (regs[rs1_addr]),
    .data    (rs1_data)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rs2 (
    .addr    (rs2_addr),
    .we      (we),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .stored  (regs[rs2_addr]),
    .data    (rs2_data)
  );

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file (bypass and no-bypass builds)
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic        we;
  logic [31:0] rd_data;

  logic [31:0] rs1_data, rs2_data, dbg_data;
  logic [15:0] wr_count;
  logic [31:0] nb_rs1_data, nb_rs2_data, nb_dbg_data;
  logic [15:0] nb_wr_count;

  int total = 0;
  int bad   = 0;

  // Reference model: plain array of architectural register values and a write tally.
  logic [31:0] model_regs [32];
  int unsigned model_cnt;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rs1_addr (rs1_addr),
    .rs1_data (rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (rs2_data),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk      (clk),
    .rstn     (rstn),
    .rs1_addr (rs1_addr),
    .rs1_data (nb_rs1_data),
    .rs2_addr (rs2_addr),
    .rs2_data (nb_rs2_data),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dbg_addr (dbg_addr),
    .dbg_data (nb_dbg_data),
    .wr_count (nb_wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit fwd);
    if (a == 5'd0) return 32'h0;
    if (fwd && we && rd_addr == a) return rd_data;
    return model_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":rs1"},    rs1_data,    ref_read(rs1_addr, 1'b1));
    chk({tag, ":rs2"},    rs2_data,    ref_read(rs2_addr, 1'b1));
    chk({tag, ":dbg"},    dbg_data,    ref_read(dbg_addr, 1'b0));
    chk({tag, ":nb_rs1"}, nb_rs1_data, ref_read(rs1_addr, 1'b0));
    chk({tag, ":nb_rs2"}, nb_rs2_data, ref_read(rs2_addr, 1'b0));
    chk({tag, ":nb_dbg"}, nb_dbg_data, ref_read(dbg_addr, 1'b0));
    chk({tag, ":cnt"},    {16'h0, wr_count},    model_cnt % 65536);
    chk({tag, ":nb_cnt"}, {16'h0, nb_wr_count}, model_cnt % 65536);
  endtask

  // Drive one cycle's inputs just after a rising edge, then commit the model at the next edge.
  task automatic drive(input logic w, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    we = w; rd_addr = rd; rd_data = d;
    rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
  endtask

  task automatic clock_commit();
    @(posedge clk);
    if (rstn && we && rd_addr != 5'd0) begin
      model_regs[rd_addr] = rd_data;
      model_cnt++;
    end
    #1;
  endtask

  task automatic step(input string tag, input logic w, input logic [4:0] rd, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    drive(w, rd, d, a1, a2, ad);
    #1;
    check_all(tag);
    clock_commit();
  endtask

  initial begin
    logic [31:0] a_val, b_val, exp_slt;
    model_reset();
    rstn = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    // 1: async reset clears a written register without a clock edge.
    step("w5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    #1;
    chk("pre_rst_x5", rs1_data, 32'hDEAD_BEEF);
    #1 rstn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_rs1", rs1_data, 32'h0);
    chk("async_rst_cnt", {16'h0, wr_count}, 32'h0);
    // A write held across an edge while in reset must not land.
    drive(1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9, 5'd9);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
    #1;
    chk("rst_blocks_wr", dbg_data, 32'h0);
    chk("rst_blocks_cnt", {16'h0, wr_count}, 32'h0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst");

    // 2: x0 writes are dropped and never forwarded.
    step("x0_wr", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    step("x0_after", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

    // 3/4: bypass versus stored-only build on an unwritten x7.
    drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 5'd7);
    #1;
    chk("byp_rs1", rs1_data, 32'h1234_5678);
    chk("byp_rs2", rs2_data, 32'h1234_5678);
    chk("byp_dbg", dbg_data, 32'h0);
    chk("nobyp_rs1_pre", nb_rs1_data, 32'h0);
    clock_commit();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    #1;
    chk("byp_dbg_post", dbg_data, 32'h1234_5678);
    chk("nobyp_rs1_post", nb_rs1_data, 32'h1234_5678);

    // 5: fill x1..x31 and read back mirrored pairs.
    rstn = 1'b0; #1; model_reset(); #1 rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0, 5'd0);
      clock_commit();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
      #1;
      chk("fill_rs1", rs1_data, 32'(i) * 32'h0101_0101);
      chk("fill_rs2", rs2_data, 32'(31 - i) * 32'h0101_0101);
      #1;
    end
    chk("fill_cnt", {16'h0, wr_count}, 32'd31);

    // Randomized traffic against the model, including same-index reads and x0 targets.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] r;
      r = 5'($urandom_range(0, 31));
      step("rand", 1'($urandom), r, $urandom,
           ($urandom_range(0, 3) == 0) ? r : 5'($urandom),
           ($urandom_range(0, 3) == 0) ? r : 5'($urandom),
           ($urandom_range(0, 3) == 0) ? r : 5'($urandom));
    end

    // 6: operands feed a signed set-less-than.
    step("alu_w1", 1'b1, 5'd1, 32'd5, 5'd0, 5'd0, 5'd0);
    step("alu_w2", 1'b1, 5'd2, 32'd7, 5'd0, 5'd0, 5'd0);
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 5'd0, 32'h0, (s == 0) ? 5'd1 : 5'd2, (s == 0) ? 5'd2 : 5'd1, 5'd0);
      #1;
      a_val = rs1_data; b_val = rs2_data;
      exp_slt = (s == 0) ? 32'd1 : 32'd0;
      chk("alu_slt", {31'h0, $signed(a_val) < $signed(b_val)}, exp_slt);
      #1;
    end

    // wr_count wraps from FFFF to 0000.
    drive(1'b1, 5'd3, 32'h0, 5'd0, 5'd0, 5'd0);
    while ((model_cnt % 65536) != 65535) begin
      rd_data = 32'(model_cnt);
      clock_commit();
    end
    #1;
    chk("cnt_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
    clock_commit();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 5'd3);
    #1;
    chk("cnt_wrap", {16'h0, wr_count}, 32'h0);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
